// File: rtl/pcie_phy_pkg.sv
// Shared PHY types for the lane receive path: special K codes, TS identifiers,
// training control bits and the TS1/TS2 receive decoder state.
package pcie_phy_pkg;

  typedef enum logic [7:0] {
    K28_5 = 8'hBC,
    K23_7 = 8'hF7
  } phy_special_k_e;

  typedef enum logic [7:0] {
    TS1 = 8'h4A,
    TS2 = 8'h45,
    PAD = 8'hF7
  } train_seq_e;

  typedef enum logic [7:0] {
    RATE_GEN1      = 8'h02,
    RATE_GEN1_GEN2 = 8'h06
  } rate_id_e;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       compliance_rx;
    logic       scramble_dis;
    logic       loopback;
    logic       link_disable;
    logic       hot_reset;
  } training_ctrl_t;

  localparam int unsigned TSOS_LEN = 16;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tsos_rx_state_e;

  // Everything that must match for two sets to count as identical.
  typedef struct packed {
    logic           is_ts2;
    logic [7:0]     link_num;
    logic [7:0]     lane_num;
    logic           link_pad;
    logic           lane_pad;
    logic [7:0]     n_fts;
    logic [7:0]     rate_id;
    training_ctrl_t train_ctl;
  } tsos_key_t;

  function automatic logic is_ts_id(input logic [7:0] b);
    return (b == TS1) || (b == TS2);
  endfunction

endpackage

// File: rtl/pcie_tsos_rx_decoder.sv
// TS1/TS2 ordered-set decoder for one 8b/10b lane: COM alignment, field capture,
// validation and identical-set counting (counter built with PCIE_TSOS_CONSEC_CNT_EN).
module pcie_tsos_rx_decoder
  import pcie_phy_pkg::*;
#(
  parameter int unsigned CONSEC_TARGET = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_datak_i,
  input  logic       rx_valid_i,
  output logic       ts_valid_o,
  output logic       ts_is_ts2_o,
  output logic [7:0] ts_link_num_o,
  output logic [7:0] ts_lane_num_o,
  output logic       ts_link_pad_o,
  output logic       ts_lane_pad_o,
  output logic [7:0] ts_n_fts_o,
  output logic [7:0] ts_rate_id_o,
  output logic [7:0] ts_train_ctl_o,
  output logic       ts_error_o,
  output logic       ts_consec_met_o
);

  localparam logic [3:0] LastIdx = 4'(TSOS_LEN - 1);

  tsos_rx_state_e state_q;
  logic [3:0]     idx_q;
  logic [7:0]     type_q, link_q, lane_q, nfts_q, rate_q, ctl_q;
  logic           link_pad_q, lane_pad_q;
  tsos_key_t      out_q;
  logic           ts_valid_q, ts_error_q;

  logic      is_com, is_pad, sym_ok;
  logic      take_valid, take_err;
  tsos_key_t new_key;

  always_comb begin
    is_com = rx_datak_i && (rx_data_i == K28_5);
    is_pad = rx_datak_i && (rx_data_i == K23_7);

    sym_ok = 1'b0;
    if (idx_q == 4'd1 || idx_q == 4'd2) begin
      sym_ok = !rx_datak_i || is_pad;
    end else if (idx_q >= 4'd3 && idx_q <= 4'd5) begin
      sym_ok = !rx_datak_i;
    end else if (idx_q == 4'd6) begin
      sym_ok = !rx_datak_i && is_ts_id(rx_data_i);
    end else if (idx_q >= 4'd7) begin
      sym_ok = !rx_datak_i && (rx_data_i == type_q);
    end

    take_valid = rx_valid_i && (state_q == COLLECT) && sym_ok && (idx_q == LastIdx);
    take_err   = rx_valid_i && (state_q == COLLECT) && !sym_ok;

    new_key.is_ts2    = (type_q == TS2);
    new_key.link_num  = link_q;
    new_key.lane_num  = lane_q;
    new_key.link_pad  = link_pad_q;
    new_key.lane_pad  = lane_pad_q;
    new_key.n_fts     = nfts_q;
    new_key.rate_id   = rate_q;
    new_key.train_ctl = ctl_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HUNT;
      idx_q      <= 4'd0;
      type_q     <= 8'h00;
      link_q     <= 8'h00;
      lane_q     <= 8'h00;
      nfts_q     <= 8'h00;
      rate_q     <= 8'h00;
      ctl_q      <= 8'h00;
      link_pad_q <= 1'b0;
      lane_pad_q <= 1'b0;
      out_q      <= '0;
      ts_valid_q <= 1'b0;
      ts_error_q <= 1'b0;
    end else begin
      ts_valid_q <= 1'b0;
      ts_error_q <= 1'b0;
      if (rx_valid_i) begin
        case (state_q)
          HUNT: begin
            if (is_com) begin
              state_q <= COLLECT;
              idx_q   <= 4'd1;
            end
          end
          COLLECT: begin
            if (!sym_ok) begin
              ts_error_q <= 1'b1;
              // A COM in the wrong place is taken as the start of a new set.
              if (is_com) begin
                idx_q <= 4'd1;
              end else begin
                state_q <= HUNT;
                idx_q   <= 4'd0;
              end
            end else begin
              case (idx_q)
                4'd1: begin
                  link_q     <= rx_data_i;
                  link_pad_q <= rx_datak_i;
                end
                4'd2: begin
                  lane_q     <= rx_data_i;
                  lane_pad_q <= rx_datak_i;
                end
                4'd3:    nfts_q <= rx_data_i;
                4'd4:    rate_q <= rx_data_i;
                4'd5:    ctl_q  <= rx_data_i;
                4'd6:    type_q <= rx_data_i;
                default: ;
              endcase
              if (idx_q == LastIdx) begin
                out_q      <= new_key;
                ts_valid_q <= 1'b1;
                state_q    <= HUNT;
                idx_q      <= 4'd0;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= HUNT;
            idx_q   <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef PCIE_TSOS_CONSEC_CNT_EN
  localparam logic [3:0] TargetCnt = 4'(CONSEC_TARGET);

  logic [3:0] cnt_q, cnt_d;
  logic       met_q;

  // out_q still holds the previous set's key when the new set completes.
  always_comb begin
    cnt_d = 4'd1;
    if (new_key == out_q) begin
      cnt_d = (cnt_q >= TargetCnt) ? TargetCnt : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
      met_q <= 1'b0;
    end else if (take_err) begin
      cnt_q <= 4'd0;
      met_q <= 1'b0;
    end else if (take_valid) begin
      cnt_q <= cnt_d;
      met_q <= (cnt_d >= TargetCnt);
    end
  end

  assign ts_consec_met_o = met_q;
`else
  logic unused_target;
  assign unused_target   = ^CONSEC_TARGET;
  assign ts_consec_met_o = 1'b0;
`endif

  assign ts_valid_o     = ts_valid_q;
  assign ts_error_o     = ts_error_q;
  assign ts_is_ts2_o    = out_q.is_ts2;
  assign ts_link_num_o  = out_q.link_num;
  assign ts_lane_num_o  = out_q.lane_num;
  assign ts_link_pad_o  = out_q.link_pad;
  assign ts_lane_pad_o  = out_q.lane_pad;
  assign ts_n_fts_o     = out_q.n_fts;
  assign ts_rate_id_o   = out_q.rate_id;
  assign ts_train_ctl_o = out_q.train_ctl;

endmodule
